// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store sequencer.
// Access sizes, FSM state encoding and the alignment rule.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    // Size 3 is reserved and behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SzHalf) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering for loads (extract + extend) and sub-word stores (merge into a word).
// Purely combinational; lanes are little-endian.
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        merge_o  = wdata_i;
        case (size_i)
            SzByte: begin
                load_o  = uns_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merge_o = word_i;
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SzHalf: begin
                load_o  = uns_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                merge_o = word_i;
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: maps byte/half/word accesses onto a word-wide RAM,
// using read-modify-write for sub-word stores and stalling the pipeline until done.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned RamLat = 1,
    parameter int unsigned AddrW  = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cpu_en_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             stall_o,
    output logic             misalign_o,
    output logic             ram_cs_o,
    output logic             ram_wen_o,
    output logic [AddrW-1:0] ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      ram_rdata_i,
    input  logic             ram_stall_i
);

    localparam logic [2:0] LastCnt = 3'(RamLat - 1);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ram_cs_q, ram_cs_d;
    logic             ram_wen_q, ram_wen_d;
    logic [AddrW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]      ram_wdata_q, ram_wdata_d;
    logic             we_q, we_d;
    logic             uns_q, uns_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       lane_q, lane_d;
    logic             mis;
    logic [31:0]      load_val;
    logic [31:0]      merge_val;
    logic             unused_addr;

    assign unused_addr = ^addr_i[31:AddrW+2];

    assign mis         = is_misaligned(size_i, addr_i[1:0]);
    assign misalign_o  = req_i & mis;
    assign stall_o     = req_i & ~mis & (state_q != StDone);
    assign rdata_o     = misalign_o ? '0 : rdata_q;
    assign ram_cs_o    = ram_cs_q;
    assign ram_wen_o   = ram_wen_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

    // The access attributes are latched so a flushed request still completes correctly.
    mem_access_unit_lane_align u_lane_align (
        .size_i  (size_q),
        .uns_i   (uns_q),
        .lane_i  (lane_q),
        .word_i  (ram_rdata_i),
        .wdata_i (ram_wdata_q),
        .load_o  (load_val),
        .merge_o (merge_val)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        ram_cs_d    = ram_cs_q;
        ram_wen_d   = ram_wen_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        lane_d      = lane_q;
        if (cpu_en_i && !ram_stall_i) begin
            unique case (state_q)
                StIdle: begin
                    if (req_i && !mis) begin
                        cnt_d      = '0;
                        ram_addr_d = addr_i[AddrW+1:2];
                        we_d       = we_i;
                        uns_d      = uns_i;
                        size_d     = size_i;
                        lane_d     = addr_i[1:0];
                        ram_cs_d   = 1'b1;
                        // Sub-word stores keep raw wdata here until the merge in StRd.
                        if (we_i) begin
                            ram_wdata_d = wdata_i;
                        end
                        if (we_i && size_i[1]) begin
                            ram_wen_d = 1'b1;
                            state_d   = StWr;
                        end else begin
                            ram_wen_d = 1'b0;
                            state_d   = StRd;
                        end
                    end
                end
                StRd: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LastCnt) begin
                        if (we_q) begin
                            ram_wdata_d = merge_val;
                            ram_wen_d   = 1'b1;
                            state_d     = StWr;
                        end else begin
                            rdata_d  = load_val;
                            ram_cs_d = 1'b0;
                            state_d  = StDone;
                        end
                    end
                end
                StWr: begin
                    ram_cs_d  = 1'b0;
                    ram_wen_d = 1'b0;
                    state_d   = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rdata_q     <= '0;
            ram_cs_q    <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= SzByte;
            lane_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            ram_cs_q    <= ram_cs_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts each access,
// a negedge monitor checks every completion; a second instance covers a 3-cycle RAM.
module tb_mem_access_unit;

    localparam int unsigned AddrW  = 10;
    localparam int unsigned RamLat = 1;

    typedef struct {
        logic        mis;
        logic [31:0] rdata;
        int          stall;
        logic [9:0]  waddr;
        logic [31:0] wval;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cpu_en, req, req3, we, uns, ram_stall;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, ram_wdata, ram_rdata;
    logic        stall, misalign, ram_cs, ram_wen;
    logic [AddrW-1:0] ram_addr;
    logic [31:0] rdata3, ram3_wdata, ram3_rdata;
    logic        stall3, misalign3, ram3_cs, ram3_wen;
    logic [AddrW-1:0] ram3_addr;

    logic [31:0] ram_mem  [0:1023];
    logic [31:0] ram3_mem [0:1023];
    bit          ram_init  = 1'b0;
    bit          ram3_init = 1'b0;
    int          rd_cnt3   = 0;

    logic [7:0]  ref_b [0:4095];
    logic [31:0] last_load;
    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;

    mem_access_unit #(.RamLat(RamLat), .AddrW(AddrW)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .cpu_en_i(cpu_en), .req_i(req), .we_i(we),
        .size_i(size), .uns_i(uns), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .stall_o(stall), .misalign_o(misalign), .ram_cs_o(ram_cs), .ram_wen_o(ram_wen),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .ram_stall_i(ram_stall)
    );

    mem_access_unit #(.RamLat(3), .AddrW(AddrW)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .cpu_en_i(cpu_en), .req_i(req3), .we_i(we),
        .size_i(size), .uns_i(uns), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata3),
        .stall_o(stall3), .misalign_o(misalign3), .ram_cs_o(ram3_cs), .ram_wen_o(ram3_wen),
        .ram_addr_o(ram3_addr), .ram_wdata_o(ram3_wdata), .ram_rdata_i(ram3_rdata),
        .ram_stall_i(ram_stall)
    );

    function automatic logic [31:0] seed(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // RAM models: single-cycle read for the main instance, 3-cycle read for the second.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= seed(i);
            ram_init <= 1'b1;
        end else if (ram_cs && ram_wen && !ram_stall) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = (ram_cs && !ram_wen) ? ram_mem[ram_addr] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!ram3_init) begin
            for (int i = 0; i < 1024; i++) ram3_mem[i] <= seed(i);
            ram3_init <= 1'b1;
        end else begin
            if (ram3_cs && ram3_wen && !ram_stall) ram3_mem[ram3_addr] <= ram3_wdata;
            if (!ram3_cs) rd_cnt3 <= 0;
            else if (!ram3_wen && cpu_en && !ram_stall) rd_cnt3 <= rd_cnt3 + 1;
        end
    end
    assign ram3_rdata = (ram3_cs && !ram3_wen && rd_cnt3 >= 2) ? ram3_mem[ram3_addr]
                                                                : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_b[4*wa+3], ref_b[4*wa+2], ref_b[4*wa+1], ref_b[4*wa]};
    endfunction

    // Monitor: every cycle the pipeline may advance (req & !stall) retires one expectation.
    initial begin
        int   scnt;
        bit   cs_chk;
        exp_t e;
        scnt   = 0;
        cs_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (cs_chk) begin
                chk("mis_no_cs", {31'b0, ram_cs}, 32'd0);
                cs_chk = 1'b0;
            end
            if (!rst_n || !req) begin
                scnt = 0;
            end else if (stall) begin
                scnt++;
            end else if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got completion, expected none (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
                chk("rdata", rdata, e.rdata);
                chk("stall_cycles", scnt, e.stall);
                chk("ram_word", ram_mem[e.waddr], e.wval);
                if (e.mis) begin
                    chk("mis_cs_now", {31'b0, ram_cs}, 32'd0);
                    cs_chk = 1'b1;
                end
                scnt = 0;
            end
        end
    end

    // Issue one access; f1 = ram_stall cycles in the second step, f2 = cpu_en-low cycles in the third.
    task automatic do_op(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, input int f1, input int f2, input bit rnd);
        exp_t        e;
        int          n, ba, base, adv, left;
        int          plan[3];
        bit          fz, done;
        logic [31:0] v;
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ba      = int'(a[11:0]);
        e.mis   = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        e.waddr = a[11:2];
        if (!e.mis) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_b[ba+i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[ba+i];
                if (!u && n == 1 && v[7]) v[31:8] = '1;
                if (!u && n == 2 && v[15]) v[31:16] = '1;
                last_load = v;
            end
        end
        base = !w ? 1 + RamLat : (n == 4) ? 2 : 2 + RamLat;
        plan = '{0, f1, f2};
        if (rnd) for (int i = 0; i < 3; i++) plan[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
        e.stall = 0;
        if (!e.mis) begin
            e.stall = base;
            for (int i = 0; i < base; i++) e.stall += plan[i];
        end
        e.rdata = e.mis ? '0 : last_load;
        e.wval  = ref_word(int'(e.waddr));
        sb_q.push_back(e);
        we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
        if (e.mis) begin
            @(posedge clk); #1;
            req = 1'b0;
            return;
        end
        adv  = 0;
        left = plan[0];
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            fz = (adv < base) && (left > 0);
            if (fz) left--;
            cpu_en    = !(fz && adv != 1);
            ram_stall = fz && adv == 1;
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (!fz) begin
                    adv++;
                    left = (adv < base) ? plan[adv] : 0;
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL op_timeout: got stall still high, expected completion (t=%0t)", $time);
        end
        @(posedge clk); #1;
        req = 1'b0; cpu_en = 1'b1; ram_stall = 1'b0;
    endtask

    task automatic op3(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input int exp_st, input logic [31:0] exp_rd,
                       input string nm);
        int cnt;
        bit done;
        cnt  = 0;
        done = 1'b0;
        we = w; size = sz; uns = u; addr = a; wdata = d; req3 = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (!stall3) begin
                done = 1'b1;
            end else begin
                cnt++;
                @(posedge clk); #1;
            end
        end
        chk({nm, "_stall"}, cnt, exp_st);
        chk({nm, "_rdata"}, rdata3, exp_rd);
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] s;
        for (int i = 0; i < 1024; i++) begin
            s = seed(i);
            for (int k = 0; k < 4; k++) ref_b[4*i+k] = s[8*k +: 8];
        end
        last_load = '0;
        rst_n = 1'b0; cpu_en = 1'b1; ram_stall = 1'b0; req = 1'b0; req3 = 1'b0;
        we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {31'b0, ram_cs}, 32'd0);
        chk("rst_wen", {31'b0, ram_wen}, 32'd0);
        chk("rst_addr", {22'b0, ram_addr}, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, 0, 0, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 0, 1'b0);
        do_op(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AA, 0, 0, 1'b0);
        chk("s2_word", ram_mem[16], 32'h1122_AA44);
        do_op(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 0, 0, 1'b0);
        do_op(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 0, 0, 1'b0);
        do_op(1'b1, 2'd1, 1'b0, 32'h42, 32'h0000_8001, 0, 0, 1'b0);
        chk("s3_word", ram_mem[16], 32'h8001_AA44);
        do_op(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 0, 0, 1'b0);
        do_op(1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 0, 0, 1'b0);
        do_op(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, 0, 0, 1'b0);
        do_op(1'b0, 2'd1, 1'b0, 32'h43, 32'h0, 0, 0, 1'b0);
        do_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h1122_3344, 0, 0, 1'b0);
        do_op(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00AA, 3, 2, 1'b0);
        chk("s5_word", ram_mem[16], 32'h1122_AA44);
        do_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 0, 1'b0);

        // Reset while the byte store sits in its read phase: nothing may be written.
        we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h44; wdata = 32'h55; req = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_cs", {31'b0, ram_cs}, 32'd0);
        chk("rstmid_wen", {31'b0, ram_wen}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        last_load = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_nowrite", ram_mem[17], ref_word(17));

        // Flush: request withdrawn after acceptance, the store still lands.
        we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h45; wdata = 32'h77; req = 1'b1;
        ref_b[32'h45] = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        do_op(1'b0, 2'd0, 1'b1, 32'h45, 32'h0, 0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h40 + 32'($urandom_range(0, 31)), $urandom, 0, 0, 1'b1);
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1;
        end

        s = seed(32);
        op3(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 4, s, "lat3_lw");
        op3(1'b1, 2'd1, 1'b0, 32'h82, 32'h1234, 5, s, "lat3_sh");
        op3(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, 4, 32'h0000_1234, "lat3_lhu");
        op3(1'b0, 2'd0, 1'b0, 32'h81, 32'h0, 4, {{24{s[15]}}, s[15:8]}, "lat3_lb");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
